// File: rtl/fp_div_pkg.sv
// ============================================================================
//  Module      : fp_div_pkg
//  Description : Shared types and width helpers for the mantissa divider.
//                Defines the divider FSM state encoding and the quotient
//                width (mantissa width plus one integer bit and one guard
//                bit).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // The quotient is two bits wider than the mantissa: one bit for a
    // quotient >= 1.0 and one guard bit below the LSB of the mantissa.
    localparam int QUOT_EXTRA = 2;

    function automatic int quot_width(input int n);
        return n + QUOT_EXTRA;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mant_div_restoring_step.sv
// ============================================================================
//  Module      : div_step
//  Description : Single restoring-division trial subtract.
//                Subtracts the divisor from the partial remainder with one
//                extra bit so the borrow is visible. The quotient bit is the
//                inverted borrow; the next (pre-shift) remainder is the
//                difference when the subtract succeeds, else the unchanged
//                remainder.
//  Ports       : r_i    [N:0]   partial remainder
//                b_i    [N-1:0] divisor
//                rem_o  [N:0]   selected remainder, before the left shift
//                bit_o          quotient bit produced by this step
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int N = 24
) (
    input  logic [N:0]   r_i,
    input  logic [N-1:0] b_i,
    output logic [N:0]   rem_o,
    output logic         bit_o
);

    logic [N+1:0] w_diff;

    assign w_diff = {1'b0, r_i} - {2'b00, b_i};
    assign bit_o  = ~w_diff[N+1];
    assign rem_o  = bit_o ? w_diff[N:0] : r_i;

endmodule

`default_nettype wire

// File: rtl/mant_div_restoring.sv
// ============================================================================
//  Module      : mant_div_restoring
//  Description : Multi-cycle restoring divider for normalized mantissas.
//                Retires one quotient bit per clock, N+2 bits in total,
//                giving q = floor(a * 2^(N+1) / b) plus a sticky bit that
//                flags a nonzero final remainder. An unnormalized divisor
//                (b[N-1] == 0) skips the iterations and reports div_err with
//                an all-ones quotient.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                in_valid / in_ready operand handshake (ready only in IDLE)
//                a, b     [N-1:0]    dividend / divisor mantissas
//                out_valid/out_ready result handshake (valid only in DONE)
//                q        [N+1:0]    quotient
//                sticky              final remainder nonzero
//                div_err             divisor was zero or unnormalized
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mant_div_restoring
    import fp_div_pkg::*;
#(
    parameter  int N  = 24,
    localparam int CW = $clog2(N + 2)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N+1:0] q,
    output logic         sticky,
    output logic         div_err
);

    localparam int QW = quot_width(N);

    div_state_t        state_q, state_d;
    logic [N:0]        rem_q, rem_d;
    logic [N-1:0]      div_q, div_d;
    logic [QW-1:0]     quo_q, quo_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sticky_q, sticky_d;
    logic              err_q, err_d;

    logic [N:0]        step_rem;
    logic              step_bit;

    div_step #(
        .N (N)
    ) u_step (
        .r_i   (rem_q),
        .b_i   (div_q),
        .rem_o (step_rem),
        .bit_o (step_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rem_d = {1'b0, a};
                    div_d = b;
                    quo_d = '0;
                    cnt_d = CW'(N + 1);
                    if (b[N-1]) begin
                        state_d = BUSY;
                    end else begin
                        quo_d    = '1;
                        sticky_d = 1'b0;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end
                end
            end

            BUSY: begin
                quo_d = {quo_q[QW-2:0], step_bit};
                // Selected remainder is always below the divisor, so its MSB
                // is zero and the shift into N+1 bits loses nothing.
                rem_d = {step_rem[N-1:0], 1'b0};
                if (cnt_q == '0) begin
                    sticky_d = |step_rem;
                    err_d    = 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q         = quo_q;
    assign sticky    = sticky_q;
    assign div_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mant_div_restoring.sv
// ============================================================================
//  Module      : tb_mant_div_restoring
//  Description : Self-checking bench for mant_div_restoring. An N=8 instance
//                runs a table of directed vectors plus hand-written
//                backpressure and mid-operation reset sequences; an N=24
//                instance runs random normalized operands against a
//                reference model and a back-to-back throughput check.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mant_div_restoring;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- N = 8 instance ----------------
    logic       iv8 = 1'b0, or8 = 1'b1;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ir8, ov8, st8, er8;
    logic [9:0] q8;

    mant_div_restoring #(.N(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .a         (a8),
        .b         (b8),
        .out_valid (ov8),
        .out_ready (or8),
        .q         (q8),
        .sticky    (st8),
        .div_err   (er8)
    );

    // ---------------- N = 24 instance ----------------
    logic        iv24 = 1'b0, or24 = 1'b1;
    logic [23:0] a24 = '0, b24 = '0;
    logic        ir24, ov24, st24, er24;
    logic [25:0] q24;

    mant_div_restoring #(.N(24)) u_dut24 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv24),
        .in_ready  (ir24),
        .a         (a24),
        .b         (b24),
        .out_valid (ov24),
        .out_ready (or24),
        .q         (q24),
        .sticky    (st24),
        .div_err   (er24)
    );

    typedef struct {
        logic [9:0] q;
        logic       st;
        logic       er;
    } exp8_t;

    typedef struct {
        logic [25:0] q;
        logic        st;
        logic        er;
    } exp24_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [9:0] q;
        logic       st;
        logic       er;
    } vec8_t;

    exp8_t  sb8[$];
    exp24_t sb24[$];
    int     pop8  = 0;
    int     pop24 = 0;
    logic   stall24 = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    // Reference: quotient and remainder of a * 2^25 / b at N=24.
    function automatic logic [26:0] ref24(input logic [23:0] a, input logic [23:0] b);
        logic [63:0] num, qq, rr;
        num = {15'd0, a, 25'd0};
        if (b[23] == 1'b0) return {1'b0, {26{1'b1}}};
        qq = num / {40'd0, b};
        rr = num % {40'd0, b};
        return {(rr != 64'd0), qq[25:0]};
    endfunction

    // ---------------- output monitors (sample on falling edge) ----------------
    always @(negedge clk) begin : mon8
        exp8_t e;
        if (!rst && ov8 && or8) begin
            if (sb8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out8_unexpected actual=q 0x%0h required=no output", q8);
            end else begin
                e = sb8.pop_front();
                chk("q8", 64'(q8), 64'(e.q));
                chk("sticky8", 64'(st8), 64'(e.st));
                chk("div_err8", 64'(er8), 64'(e.er));
            end
            pop8++;
        end
    end

    always @(negedge clk) begin : mon24
        exp24_t e;
        if (!rst && ov24 && or24) begin
            if (sb24.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out24_unexpected actual=q 0x%0h required=no output", q24);
            end else begin
                e = sb24.pop_front();
                chk("q24", 64'(q24), 64'(e.q));
                chk("sticky24", 64'(st24), 64'(e.st));
                chk("div_err24", 64'(er24), 64'(e.er));
            end
            pop24++;
        end
    end

    // Random downstream stalls for the N=24 instance.
    always @(posedge clk) begin
        #1;
        or24 = stall24 ? ($urandom_range(3) != 0) : 1'b1;
    end

    // ---------------- drivers ----------------
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [9:0] eq,
                         input logic es, input logic ee, output int acc);
        a8  = a;
        b8  = b;
        iv8 = 1'b1;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ir8) begin
                sb8.push_back('{q: eq, st: es, er: ee});
                acc = cyc + 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        if (acc < 0) fail_now("accept8_timeout");
    endtask

    task automatic send24(input logic [23:0] a, input logic [23:0] b, output int acc);
        logic [26:0] r;
        r    = ref24(a, b);
        a24  = a;
        b24  = b;
        iv24 = 1'b1;
        acc  = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ir24) begin
                sb24.push_back('{q: r[25:0], st: r[26], er: ~b[23]});
                acc = cyc + 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        iv24 = 1'b0;
        if (acc < 0) fail_now("accept24_timeout");
    endtask

    // Returns the cycle count at the first falling edge with out_valid high.
    task automatic wait_out8(output int t);
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ov8) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) fail_now("out8_timeout");
    endtask

    // ---------------- main sequence ----------------
    vec8_t vecs[8];

    initial begin
        int acc, t, prev;
        logic [23:0] ra, rb;

        vecs[0] = '{a: 8'h80, b: 8'h80, q: 10'h200, st: 1'b0, er: 1'b0};
        vecs[1] = '{a: 8'h80, b: 8'hC0, q: 10'h155, st: 1'b1, er: 1'b0};
        vecs[2] = '{a: 8'hC0, b: 8'h80, q: 10'h300, st: 1'b0, er: 1'b0};
        vecs[3] = '{a: 8'hFF, b: 8'h80, q: 10'h3FC, st: 1'b0, er: 1'b0};
        vecs[4] = '{a: 8'h00, b: 8'h80, q: 10'h000, st: 1'b0, er: 1'b0};
        vecs[5] = '{a: 8'hA5, b: 8'hB3, q: 10'h1D7, st: 1'b1, er: 1'b0};
        vecs[6] = '{a: 8'h80, b: 8'h00, q: 10'h3FF, st: 1'b0, er: 1'b1};
        vecs[7] = '{a: 8'h80, b: 8'h7F, q: 10'h3FF, st: 1'b0, er: 1'b1};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(ir8), 64'd1);
        chk("rst_out_valid", 64'(ov8), 64'd0);
        chk("rst_q", 64'(q8), 64'd0);
        chk("rst_sticky", 64'(st8), 64'd0);
        chk("rst_div_err", 64'(er8), 64'd0);
        @(posedge clk);
        #1;

        // Directed table: result via scoreboard, latency checked here.
        // Normal operands appear N+2 = 10 edges after the accept edge;
        // a bad divisor goes straight to DONE on the accept edge.
        for (int i = 0; i < 8; i++) begin
            send8(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].st, vecs[i].er, acc);
            wait_out8(t);
            chk($sformatf("latency8_v%0d", i), 64'(t - acc), vecs[i].er ? 64'd0 : 64'd10);
            @(posedge clk);
            #1;
        end
        chk("table_pops", 64'(pop8), 64'd8);

        // Backpressure with in_valid pulses in BUSY and DONE
        or8 = 1'b0;
        send8(8'h80, 8'hC0, 10'h155, 1'b1, 1'b0, acc);
        a8  = 8'hFF;
        b8  = 8'h80;
        iv8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        iv8 = 1'b0;
        wait_out8(t);
        chk("bp_latency", 64'(t - acc), 64'd10);
        iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_q", 64'(q8), 64'h155);
            chk("bp_sticky", 64'(st8), 64'd1);
            chk("bp_in_ready", 64'(ir8), 64'd0);
            chk("bp_out_valid", 64'(ov8), 64'd1);
        end
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_retire_in_ready", 64'(ir8), 64'd1);
        chk("bp_retire_out_valid", 64'(ov8), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_no_phantom", 64'(ov8), 64'd0);
        end
        chk("bp_pops", 64'(pop8), 64'd9);
        @(posedge clk);
        #1;

        // Reset in the middle of an iteration
        send8(8'h80, 8'hC0, 10'h155, 1'b1, 1'b0, acc);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb8.delete();
        @(negedge clk);
        chk("midrst_in_ready", 64'(ir8), 64'd1);
        chk("midrst_out_valid", 64'(ov8), 64'd0);
        chk("midrst_q", 64'(q8), 64'd0);
        chk("midrst_sticky", 64'(st8), 64'd0);
        @(posedge clk);
        #1;
        send8(8'hC0, 8'h80, 10'h300, 1'b0, 1'b0, acc);
        wait_out8(t);
        chk("midrst_latency", 64'(t - acc), 64'd10);
        @(posedge clk);
        #1;
        chk("midrst_pops", 64'(pop8), 64'd10);

        // Random normalized operands at N=24 with output stalls
        stall24 = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            ra = {1'b1, 23'($urandom)};
            rb = {1'b1, 23'($urandom)};
            if (i % 100 == 7)  ra = '0;
            if (i % 250 == 11) rb = 24'h7FFFFF & 24'($urandom);
            send24(ra, rb, acc);
        end

        // Back-to-back with no stalls: one result every N+4 = 28 cycles
        stall24 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sb24.size() == 0) break;
            @(posedge clk);
        end
        #1;
        prev = -1;
        for (int i = 0; i < 10; i++) begin
            send24({1'b1, 23'($urandom)}, {1'b1, 23'($urandom)}, acc);
            if (prev >= 0) chk("throughput24", 64'(acc - prev), 64'd28);
            prev = acc;
        end

        // Drain
        for (int i = 0; i < 200; i++) begin
            if (sb24.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        chk("sb24_drained", 64'(sb24.size()), 64'd0);
        chk("pops24", 64'(pop24), 64'd1510);
        chk("sb8_empty", 64'(sb8.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
